// File: rtl/weight_feed_pkg.sv
// Shared types and sizing helpers for the diagonal weight feeder.
package weight_feed_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feed_state_e;

  function automatic int stream_len(input int nch, input int depth);
    return nch + depth - 1;
  endfunction

  function automatic int cnt_w(input int nch, input int depth);
    return $clog2(stream_len(nch, depth) + 1);
  endfunction

endpackage

// File: rtl/weight_feed_skew_lane.sv
// One channel of the feeder: active-tile shift register plus registered,
// zero-forced output beat. Channel C is live for stream counts C..C+DEPTH-1.
module weight_lane
  import weight_feed_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int C     = 0,
  parameter int CW    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_load,
  input  logic [DEPTH*DW-1:0]   i_data,
  input  logic                  i_stream,
  input  logic [CW-1:0]         i_cnt,
  output logic [DW-1:0]         o_dout,
  output logic                  o_valid
);

  localparam logic [CW-1:0] OFFS  = CW'(C);
  localparam logic [CW-1:0] DEP_C = CW'(DEPTH);

  logic [DEPTH*DW-1:0] r_sr;
  logic [CW-1:0]       w_rel;
  logic                w_en;

  // cnt < C wraps to a value >= DEPTH, so one compare covers both bounds
  assign w_rel = i_cnt - OFFS;
  assign w_en  = i_stream && (w_rel < DEP_C);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr    <= '0;
      o_dout  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= w_en;
      o_dout  <= w_en ? r_sr[DW-1:0] : '0;
      // a new tile wins over the final shift of the old one on the last lane
      if (i_load)
        r_sr <= i_data;
      else if (w_en)
        r_sr <= r_sr >> DW;
    end
  end

endmodule

// File: rtl/weight_feed_skew.sv
// Ping-pong weight feeder streaming NCH channels in diagonal (skewed) order.
//   state  | meaning
//   IDLE   | no tile streaming; waits for start with a pending shadow tile
//   STREAM | cnt walks 0..L-1 across the diagonal; may chain the next tile
module weight_feed_skew
  import weight_feed_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_load_valid,
  output logic                      o_load_ready,
  input  logic [NCH*DEPTH*DW-1:0]   i_load_data,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NCH*DW-1:0]         o_dout,
  output logic [NCH-1:0]            o_dout_valid
);

  localparam int L  = stream_len(NCH, DEPTH);
  localparam int CW = cnt_w(NCH, DEPTH);
  localparam int TW = DEPTH * DW;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  feed_state_e               r_state;
  logic [CW-1:0]             r_cnt;
  logic [NCH*DEPTH*DW-1:0]   r_shadow;
  logic                      r_shadow_full;

  logic w_stream;
  logic w_last;
  logic w_swap;
  logic w_load;

  assign w_stream     = (r_state == STREAM);
  assign w_last       = w_stream && (r_cnt == LAST);
  assign w_swap       = i_start && r_shadow_full && ((r_state == IDLE) || w_last);
  assign w_load       = i_load_valid && !r_shadow_full;
  assign o_load_ready = !r_shadow_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      if (w_load)
        r_shadow <= i_load_data;
      if (w_swap)
        r_shadow_full <= 1'b0;
      else if (w_load)
        r_shadow_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      // busy covers the done beat, which lands after STREAM has ended
      o_busy <= w_stream || w_swap;
      o_done <= w_last;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_swap)
            r_state <= STREAM;
        end
        STREAM: begin
          if (w_last) begin
            r_cnt <= '0;
            if (!w_swap)
              r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    weight_lane #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .C     (c),
      .CW    (CW)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .i_load   (w_swap),
      .i_data   (r_shadow[c*TW +: TW]),
      .i_stream (w_stream),
      .i_cnt    (r_cnt),
      .o_dout   (o_dout[c*DW +: DW]),
      .o_valid  (o_dout_valid[c])
    );
  end

endmodule

// File: tb/tb_weight_feed_skew.sv
// Directed + random bench for weight_feed_skew against a tile-schedule model.
module tb_weight_feed_skew;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int L     = NCH + DEPTH - 1;
  localparam int TW    = NCH * DEPTH * DW;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [TW-1:0]     load_data = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    dout_valid;

  weight_feed_skew #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_data  (load_data),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_dout       (dout),
    .o_dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // model: every tile that began streaming, tagged with the edge it swapped in on
  int            q_s[$];
  logic [TW-1:0] q_data[$];
  logic          m_full = 1'b0;
  logic [TW-1:0] m_shadow = '0;
  int            m_edge = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0]    ev;
    logic [NCH*DW-1:0] ed;
    logic              ebusy;
    logic              edone;
    logic [TW-1:0]     tile;
    int                t;
    ev = '0; ed = '0; ebusy = 1'b0; edone = 1'b0;
    for (int i = 0; i < q_s.size(); i++) begin
      tile = q_data[i];
      t = m_edge - q_s[i] - 1;
      for (int c = 0; c < NCH; c++) begin
        if (t >= c && t < c + DEPTH) begin
          ev[c] = 1'b1;
          ed[c*DW +: DW] = tile[(c*DEPTH + (t - c))*DW +: DW];
        end
      end
      if (m_edge == q_s[i] + L) edone = 1'b1;
      if (m_edge >= q_s[i] && m_edge <= q_s[i] + L) ebusy = 1'b1;
    end
    chk("dout_valid", 64'(dout_valid), 64'(ev));
    chk("dout",       64'(dout),       64'(ed));
    chk("done",       64'(done),       64'(edone));
    chk("busy",       64'(busy),       64'(ebusy));
    chk("load_ready", 64'(load_ready), 64'(!m_full));
  endtask

  task automatic step();
    int e_next;
    bit can_swap;
    e_next = m_edge + 1;
    can_swap = (q_s.size() == 0) || (e_next >= q_s[q_s.size()-1] + L);
    if (start && m_full && can_swap) begin
      q_s.push_back(e_next);
      q_data.push_back(m_shadow);
      m_full = 1'b0;
    end else if (load_valid && !m_full) begin
      m_shadow = load_data;
      m_full   = 1'b1;
    end
    @(posedge clk);
    #1;
    m_edge = e_next;
    check_outputs();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(dout_valid), 64'(0));
    chk({tag, "_dout"},  64'(dout),       64'(0));
    chk({tag, "_done"},  64'(done),       64'(0));
    chk({tag, "_busy"},  64'(busy),       64'(0));
    chk({tag, "_ready"}, 64'(load_ready), 64'(1));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstn = 1'b0;
    load_valid = 1'b0;
    start = 1'b0;
    #1;
    chk_reset_state("rst_low");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      m_edge++;
      #1;
      chk_reset_state("rst_hold");
    end
    q_s.delete();
    q_data.delete();
    m_full = 1'b0;
    m_shadow = '0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] v;
    for (int i = 0; i < TW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [TW-1:0]  tile_a;
  logic [NCH-1:0] seq [8];
  int             dcnt;

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0111; seq[3] = 4'b1111;
    seq[4] = 4'b1110; seq[5] = 4'b1100; seq[6] = 4'b1000; seq[7] = 4'b0000;

    do_reset(3);
    step();
    chk_reset_state("post_release");

    // single tile with the c*16+k+1 pattern
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < DEPTH; k++)
        tile_a[(c*DEPTH + k)*DW +: DW] = 8'(c*16 + k + 1);
    load_data = tile_a; load_valid = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid_seq", 64'(dout_valid), 64'(seq[i]));
      chk("t2_done_cycle", 64'(done), 64'(i == 6));
      if (i < 4) chk("t2_ch0", 64'(dout[7:0]), 64'(i + 1));
      if (i >= 3 && i < 7) chk("t2_ch3", 64'(dout[31:24]), 64'(8'h31 + i - 3));
    end

    // ping-pong: B loads while A streams, start held throughout
    load_data = rand_tile(); load_valid = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b1;
    step();
    step();
    load_data = rand_tile(); load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t3_ready_low", 64'(load_ready), 64'(0));
    dcnt = 0;
    for (int i = 0; i < 2*L + 4; i++) begin
      step();
      if (done) dcnt++;
    end
    chk("t3_done_count", 64'(dcnt), 64'(2));
    start = 1'b0;

    // start with nothing pending
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_no_busy", 64'(busy), 64'(0));
    end
    start = 1'b0;

    // backpressure: later tiles offered while shadow is full are dropped
    load_data = rand_tile(); load_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      load_data = rand_tile();
      step();
    end
    load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < L + 3; i++) step();

    // reset at stream cycle 3, then a clean tile
    load_data = rand_tile(); load_valid = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    do_reset(2);
    for (int i = 0; i < L + 2; i++) begin
      step();
      chk("t6_no_done", 64'(done), 64'(0));
    end
    load_data = rand_tile(); load_valid = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < L + 3; i++) step();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 2) == 0);
      load_data  = rand_tile();
      start      = ($urandom_range(0, 3) != 0);
      step();
    end
    load_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < L + 2; i++) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
